ram_rr_ctrl: RTL and testbench
==============================

Name: ram_rr_ctrl

Overview:
Two-requester round-robin controller for the team's 16x4 synchronous RAM (posedge-sampled A/OE/WE, shared bidirectional data bus). It accepts read/write requests from two clients and sequences the RAM pins: it drives A/OE/WE, drives the data bus only during writes, and enforces bus turnaround. Read data is returned to the granted client with a one-cycle done pulse.

Parameters:
ADDR_W, 4, RAM address width (depth 2**ADDR_W)
DATA_W, 4, RAM data width

Ports:
CLK  input  1  single clock; all state changes on posedge
RST  input  1  asynchronous, active-high reset
req0  input  1  client 0 request; hold until done0
we0  input  1  client 0 op: 1=write, 0=read; stable while req0
addr0  input  ADDR_W  client 0 address; stable while req0
wdata0  input  DATA_W  client 0 write data; stable while req0
req1/we1/addr1/wdata1  input  1/1/ADDR_W/DATA_W  client 1, same rules
gnt0  output  1  client 0 owns the RAM (WR/RD1/RD2/TURN)
gnt1  output  1  client 1 owns the RAM
done0  output  1  one-cycle pulse: client 0 op complete
done1  output  1  one-cycle pulse: client 1 op complete
rdata  output  DATA_W  read data; valid while done0/done1 high for a read
A  output  ADDR_W  RAM address
OE  output  1  RAM output enable
WE  output  1  RAM write enable
DOUT  inout  DATA_W  RAM data bus; driven only in WR, else high-Z

Behaviour:
- Clock CLK, reset RST: one clock; reset is asynchronous and active-high.
- All outputs registered. Reset values: state=IDLE, A=0, OE=0, WE=0, DOUT=Z, gnt0/gnt1=0, done0/done1=0, rdata=0, RR pointer=client 0 preferred.
- States: IDLE, WR, RD1, RD2, TURN.
- IDLE: OE=0, WE=0, bus Z. Sample req0/req1 at each edge. One request pending -> grant it. Both pending -> grant the client not served last. On grant, latch op/addr/wdata into internal regs, set gnt, go WR (we=1) or RD1 (we=0). Requests are sampled in IDLE only.
- WR (1 cycle): A=addr_q, OE=1, WE=1, DOUT=wdata_q. The RAM writes at the closing edge. Next state TURN.
- RD1 (1 cycle): A=addr_q, OE=1, WE=0, bus Z. The RAM drives data at the closing edge. Next state RD2.
- RD2 (1 cycle): same pins. The RAM re-drives the same word; controller captures DOUT into rdata at the closing edge. Next state TURN.
- TURN (1 cycle): OE=0, WE=0, bus Z; the RAM releases the bus at the closing edge. done of the owner =1, gnt held. Next state IDLE; gnt cleared, RR pointer updated to the owner.
- Client rule: sample done at the edge ending TURN. Deassert req at that edge, or present a new op for back-to-back. No double service: IDLE samples only at the following edge.
- Latency from sampling edge in IDLE: write done visible 1 cycle later (TURN); read done and rdata visible 2 cycles later.
- Occupancy: write 3 cycles (IDLE+WR+TURN), read 4 cycles.
- A holds the last address in IDLE/TURN. rdata holds its value until the next read capture.
- Bus safety: the controller drives DOUT only in WR. WR is always preceded by an edge with OE=0 (IDLE), so the RAM is Z. This also covers the RAM's undefined output after power-up.
- RST mid-op: immediate return to reset values. An in-flight write may or may not have landed. An in-flight read is dropped with no done. The next op still passes through IDLE (OE=0 edge) before any drive.
- Changes to a client's inputs while its req is held are illegal; the controller uses the latched copies.

Decomposition:
- Shared package ram_ctrl_pkg: state encoding constants (IDLE, WR, RD1, RD2, TURN), default ADDR_W/DATA_W, client index constants.
- Sub-module rr_arb2: 2-way round-robin picker with inputs req[1:0], last_served, and a one-hot grant output.

Test Plan:
- Reset then req0 write addr=3, data=0xA -> WR cycle shows A=3, OE=1, WE=1, DOUT=0xA; done0 pulses 1 cycle later; DOUT=Z otherwise.
- Client 0 reads addr=3 -> RD1/RD2 show OE=1, WE=0, bus not driven by controller; done0 with rdata=0xA two cycles after the sampling edge.
- req0 and req1 asserted in the same cycle, both writes (addr 5/0x5, addr 6/0x6), held back-to-back -> grants alternate 0,1,0,1 (client 0 first after reset); memory 5=0x5, 6=0x6.
- Read by client 1 immediately followed by a write by client 0 -> TURN cycle with OE=0 sits between RD2 and WR; no cycle where both the RAM and the controller drive DOUT (no X on bus).
- Fill all 16 addresses with value=addr, then read all 16 -> every rdata equals its address; address 15 to 0 transitions are correct.
- Assert RST during RD2 -> outputs immediately at reset values, no done; a subsequent write to addr 0 value 0x7 and readback returns 0x7.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the round-robin RAM controller.
package ram_ctrl_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, TURN} state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the client not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_served ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/ram_rr_ctrl.sv
// Two-client round-robin sequencer for the 16x4 synchronous RAM; all pins registered.
module ram_rr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] A,
  output logic              OE,
  output logic              WE,
  inout  wire  [DATA_W-1:0] DOUT
);
  state_t            state, state_nxt;
  logic [1:0]        pick, gnt_q, done_q;
  logic              last_q, oe_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  rr_arb2 u_arb (
    .req         ({req1, req0}),
    .last_served (last_q),
    .gnt         (pick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pick) state_nxt = (pick[1] ? we1 : we0) ? WR : RD1;
      WR:      state_nxt = TURN;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      last_q  <= CLI1;  // client 1 "served last" so client 0 wins the first tie
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      oe_q   <= (state_nxt == WR) || (state_nxt == RD1) || (state_nxt == RD2);
      we_q   <= (state_nxt == WR);
      done_q <= (state_nxt == TURN) ? gnt_q : 2'b00;
      if (state == IDLE && |pick) begin
        gnt_q   <= pick;
        addr_q  <= pick[1] ? addr1 : addr0;
        wdata_q <= pick[1] ? wdata1 : wdata0;
      end
      if (state == TURN) begin
        gnt_q  <= 2'b00;
        last_q <= gnt_q[1] ? CLI1 : CLI0;
      end
      // RAM has been driving since the end of RD1; second edge gives a settled word
      if (state == RD2) rdata_q <= DOUT;
    end
  end

  // WE is only high in WR, which always follows an OE=0 edge, so the RAM is off the bus
  assign DOUT  = we_q ? wdata_q : {DATA_W{1'bz}};
  assign A     = addr_q;
  assign OE    = oe_q;
  assign WE    = we_q;
  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign rdata = rdata_q;
endmodule

// File: tb/tb_ram_rr_ctrl.sv
// Randomized bench for ram_rr_ctrl with a RAM model and a transaction-level reference.
module tb_ram_rr_ctrl;
  localparam int K_WR = 0, K_RD1 = 1, K_RD2 = 2, K_TURN = 3, K_IDLE = 4;

  typedef struct {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       oe;
    logic       we;
    logic [3:0] a;
    logic       bchk;
    logic [3:0] bval;
    logic [3:0] rd;
    int         kind;
  } exp_t;

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [3:0] d;
  } op_t;

  logic CLK, RST;
  logic req0, we0, req1, we1;
  logic [3:0] addr0, wdata0, addr1, wdata1;
  logic gnt0, gnt1, done0, done1, OE, WE;
  logic [3:0] rdata, A;
  wire  [3:0] bus;

  // RAM model: registered output, drives while it last sampled OE=1/WE=0
  logic [3:0] ram [16];
  logic       ram_drv;
  logic [3:0] ram_q;
  assign bus = ram_drv ? ram_q : 4'bzzzz;
  always @(posedge CLK) begin
    if (OE && WE) ram[A] <= bus;
    ram_drv <= OE && !WE;
    ram_q   <= ram[A];
  end

  ram_rr_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .A(A), .OE(OE), .WE(WE), .DOUT(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int         nchk = 0;
  int         nbad = 0;
  exp_t       expq[$];
  op_t        opq0[$], opq1[$];
  logic [3:0] ref_mem [16];
  logic       last_m = 1'b1;
  logic [3:0] a_cur = 4'h0;
  logic [3:0] rdata_cur = 4'h0;
  int         last_kind = K_IDLE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] g, input logic [1:0] dn, input logic oe,
                              input logic we, input logic [3:0] a, input logic bc,
                              input logic [3:0] bv, input logic [3:0] rd, input int k);
    exp_t e;
    e.gnt = g; e.done = dn; e.oe = oe; e.we = we; e.a = a;
    e.bchk = bc; e.bval = bv; e.rd = rd; e.kind = k;
    return e;
  endfunction

  task automatic push(input int c, input logic w, input logic [3:0] a, input logic [3:0] d);
    op_t o;
    o.we = w; o.a = a; o.d = d;
    if (c == 0) opq0.push_back(o); else opq1.push_back(o);
  endtask

  task automatic load(input int c);
    op_t o;
    if (c == 0) begin o = opq0.pop_front(); req0 = 1; we0 = o.we; addr0 = o.a; wdata0 = o.d; end
    else        begin o = opq1.pop_front(); req1 = 1; we1 = o.we; addr1 = o.a; wdata1 = o.d; end
  endtask

  // One cycle: check the pins against the expected cycle, act as the clients, predict grants.
  task automatic step();
    exp_t e;
    bit   idle_now;
    int   w;
    logic [1:0] g;
    logic [3:0] a, d, v;
    logic isw;
    @(negedge CLK);
    if (expq.size() > 0) begin
      e = expq.pop_front(); idle_now = 0;
      a_cur = e.a; rdata_cur = e.rd;
    end else begin
      e = mk(2'b00, 2'b00, 1'b0, 1'b0, a_cur, 1'b0, 4'h0, rdata_cur, K_IDLE);
      idle_now = 1;
    end
    last_kind = e.kind;
    chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, e.gnt});
    chk("done", {30'd0, done1, done0}, {30'd0, e.done});
    chk("OE", {31'd0, OE}, {31'd0, e.oe});
    chk("WE", {31'd0, WE}, {31'd0, e.we});
    chk("A", {28'd0, A}, {28'd0, e.a});
    chk("rdata", {28'd0, rdata}, {28'd0, e.rd});
    if (e.bchk) chk("bus", {28'd0, bus}, {28'd0, e.bval});
    if (ram_drv && WE) chk("bus_contention", 32'd1, 32'd0);

    if (done0) begin if (opq0.size() > 0) load(0); else req0 = 0; end
    else if (!req0 && opq0.size() > 0 && $urandom_range(3) != 0) load(0);
    if (done1) begin if (opq1.size() > 0) load(1); else req1 = 0; end
    else if (!req1 && opq1.size() > 0 && $urandom_range(3) != 0) load(1);

    if (idle_now && (req0 || req1)) begin
      if (req0 && req1) w = (last_m == 1'b0) ? 1 : 0;
      else              w = req1 ? 1 : 0;
      last_m = (w == 1);
      g   = (w == 1) ? 2'b10 : 2'b01;
      a   = (w == 1) ? addr1 : addr0;
      d   = (w == 1) ? wdata1 : wdata0;
      isw = (w == 1) ? we1 : we0;
      if (isw) begin
        ref_mem[a] = d;
        expq.push_back(mk(g, 2'b00, 1'b1, 1'b1, a, 1'b1, d, rdata_cur, K_WR));
        expq.push_back(mk(g, g, 1'b0, 1'b0, a, 1'b0, 4'h0, rdata_cur, K_TURN));
      end else begin
        v = ref_mem[a];
        expq.push_back(mk(g, 2'b00, 1'b1, 1'b0, a, 1'b0, 4'h0, rdata_cur, K_RD1));
        expq.push_back(mk(g, 2'b00, 1'b1, 1'b0, a, 1'b1, v, rdata_cur, K_RD2));
        expq.push_back(mk(g, g, 1'b0, 1'b0, a, 1'b0, 4'h0, v, K_TURN));
      end
    end
  endtask

  task automatic run(input int maxc);
    int n = 0;
    while (opq0.size() > 0 || opq1.size() > 0 || req0 || req1 || expq.size() > 0) begin
      step();
      n++;
      if (n > maxc) begin
        chk("timeout", 32'd1, 32'd0);
        break;
      end
    end
    step();
  endtask

  initial begin
    int n;
    RST = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_pins", {26'd0, OE, WE, A}, 32'd0);
    chk("rst_rdata", {28'd0, rdata}, 32'd0);
    RST = 0;

    push(0, 1, 4'h3, 4'hA); run(50);
    push(0, 0, 4'h3, 4'h0); run(50);

    for (int i = 0; i < 16; i++) push(0, 1, i[3:0], i[3:0]);
    for (int i = 0; i < 16; i++) push(0, 0, i[3:0], 4'h0);
    run(400);
    for (int i = 0; i < 16; i++) chk("fill_ram", {28'd0, ram[i]}, i);

    push(0, 1, 4'h5, 4'h5); push(0, 1, 4'h5, 4'h5);
    push(1, 1, 4'h6, 4'h6); push(1, 1, 4'h6, 4'h6);
    run(100);
    chk("mem5", {28'd0, ram[5]}, 32'h5);
    chk("mem6", {28'd0, ram[6]}, 32'h6);

    push(1, 0, 4'h3, 4'h0); push(0, 1, 4'h4, 4'hC);
    run(100);

    for (int i = 0; i < 200; i++)
      push($urandom_range(1), 1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    run(3000);

    // reset while a read sits in RD2
    push(0, 0, 4'h9, 4'h0);
    n = 0;
    do begin step(); n++; end while (last_kind != K_RD2 && n < 20);
    chk("reach_rd2", last_kind, K_RD2);
    RST = 1;
    #1;
    chk("midrst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("midrst_done", {30'd0, done1, done0}, 32'd0);
    chk("midrst_pins", {26'd0, OE, WE, A}, 32'd0);
    chk("midrst_rdata", {28'd0, rdata}, 32'd0);
    req0 = 0; req1 = 0;
    expq.delete();
    last_m = 1'b1; a_cur = 4'h0; rdata_cur = 4'h0;
    step(); step();
    RST = 0;
    push(0, 1, 4'h0, 4'h7); push(0, 0, 4'h0, 4'h0);
    run(100);
    chk("post_rst_rd", {28'd0, rdata}, 32'h7);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
